// File: rtl/ram_responder_pkg.sv
// Shared types and defaults for the RAM responder: FSM state encoding,
// default line geometry shared with the cache data path, latency counter sizing.
package ram_responder_pkg;

    localparam int RAM_ADDR_W_DEF = 8;
    localparam int RAM_LINE_W_DEF = 32;
    localparam int RAM_CNT_W      = 8;

    typedef enum logic [1:0] {
        RAM_IDLE = 2'd0,
        RAM_WAIT = 2'd1,
        RAM_ACK  = 2'd2
    } ram_state_t;

    // Counter preload so that the ack lands LATENCY edges after acceptance.
    function automatic logic [RAM_CNT_W-1:0] lat_init(input int latency);
        return RAM_CNT_W'(latency - 1);
    endfunction

endpackage

// File: rtl/ram_array.sv
// Single-port synchronous line storage: registered read, write on we, no reset
// (contents survive responder reset).
module ram_array
    import ram_responder_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W_DEF,
    parameter int LINE_W = RAM_LINE_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LINE_W-1:0] wdata,
    output logic [LINE_W-1:0] rdata
);

    logic [LINE_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/ram_responder.sv
// Memory-side responder for the cache<->RAM handshake with modelled latency.
// Optional completion counters stat_rd/stat_wr are built when RAM_STATS_EN is defined.
module ram_responder
    import ram_responder_pkg::*;
#(
    parameter int ADDR_W  = RAM_ADDR_W_DEF,
    parameter int LINE_W  = RAM_LINE_W_DEF,
`ifdef RAM_STATS_EN
    parameter int STAT_W  = 16,
`endif
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              not_reset,
    input  logic              ram_avalid,
    input  logic              ram_wr,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic [LINE_W-1:0] ram_wdata,
    output logic [LINE_W-1:0] ram_rdata,
    output logic              ram_ack,
`ifdef RAM_STATS_EN
    output logic              ram_busy,
    output logic [STAT_W-1:0] stat_rd,
    output logic [STAT_W-1:0] stat_wr
`else
    output logic              ram_busy
`endif
);

    if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
        $error("ram_responder: LATENCY must be in 1..255");
    end

    localparam logic [RAM_CNT_W-1:0] CNT_INIT = lat_init(LATENCY);

    ram_state_t           state;
    logic [RAM_CNT_W-1:0] cnt;
    logic                 wr_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [LINE_W-1:0]    wdata_q;
    logic [LINE_W-1:0]    arr_rdata;
    logic [ADDR_W-1:0]    arr_addr;
    logic                 commit;

    // The WAIT->ACK edge is where storage is written or read data captured.
    assign commit = (state == RAM_WAIT) && (cnt == '0);

    // In IDLE the array already reads the incoming address so that a
    // LATENCY=1 read has its data ready at the commit edge.
    assign arr_addr = (state == RAM_IDLE) ? ram_addr : addr_q;

    ram_array #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W)
    ) u_array (
        .clk   (clk),
        .we    (commit && wr_q),
        .addr  (arr_addr),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk or negedge not_reset) begin
        if (!not_reset) begin
            state     <= RAM_IDLE;
            cnt       <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ram_ack   <= 1'b0;
            ram_busy  <= 1'b0;
            ram_rdata <= '0;
        end else begin
            case (state)
                RAM_IDLE: begin
                    ram_ack <= 1'b0;
                    if (ram_avalid) begin
                        wr_q     <= ram_wr;
                        addr_q   <= ram_addr;
                        wdata_q  <= ram_wdata;
                        cnt      <= CNT_INIT;
                        ram_busy <= 1'b1;
                        state    <= RAM_WAIT;
                    end
                end
                RAM_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        ram_ack <= 1'b1;
                        if (!wr_q) ram_rdata <= arr_rdata;
                        state <= RAM_ACK;
                    end
                end
                RAM_ACK: begin
                    ram_ack  <= 1'b0;
                    ram_busy <= 1'b0;
                    state    <= RAM_IDLE;
                end
                default: begin
                    ram_ack  <= 1'b0;
                    ram_busy <= 1'b0;
                    state    <= RAM_IDLE;
                end
            endcase
        end
    end

`ifdef RAM_STATS_EN
    // Saturating completion counters.
    always_ff @(posedge clk or negedge not_reset) begin
        if (!not_reset) begin
            stat_rd <= '0;
            stat_wr <= '0;
        end else if (commit) begin
            if (wr_q && stat_wr != '1) stat_wr <= stat_wr + 1'b1;
            if (!wr_q && stat_rd != '1) stat_rd <= stat_rd + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder: the driver queues expected acks (cycle and
// read data), a negedge monitor pops and compares on every ram_ack pulse.
module tb_ram_responder;

    localparam int ADDR_W  = 8;
    localparam int LINE_W  = 32;
    localparam int LATENCY = 4;
`ifdef RAM_STATS_EN
    localparam int STAT_W  = 2;
`endif

    logic              clk = 1'b0;
    logic              not_reset = 1'b0;
    logic              ram_avalid = 1'b0;
    logic              ram_wr = 1'b0;
    logic [ADDR_W-1:0] ram_addr = '0;
    logic [LINE_W-1:0] ram_wdata = '0;
    logic [LINE_W-1:0] ram_rdata;
    logic              ram_ack;
    logic              ram_busy;
`ifdef RAM_STATS_EN
    logic [STAT_W-1:0] stat_rd;
    logic [STAT_W-1:0] stat_wr;
`endif

    ram_responder #(
        .ADDR_W  (ADDR_W),
        .LINE_W  (LINE_W),
`ifdef RAM_STATS_EN
        .STAT_W  (STAT_W),
`endif
        .LATENCY (LATENCY)
    ) dut (
        .clk        (clk),
        .not_reset  (not_reset),
        .ram_avalid (ram_avalid),
        .ram_wr     (ram_wr),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .ram_ack    (ram_ack),
`ifdef RAM_STATS_EN
        .ram_busy   (ram_busy),
        .stat_rd    (stat_rd),
        .stat_wr    (stat_wr)
`else
        .ram_busy   (ram_busy)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_fail = 0;
    int   n_issued = 0;
    int   n_acks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (not_reset && ram_ack) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_ack: got ram_ack=1, required 0 (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                n_acks++;
                check("ack_cycle", 32'(cyc), 32'(e.cyc));
                if (!e.wr) check("rdata", ram_rdata, e.data);
            end
        end
    end

    // Called #1 after a rising edge with the DUT idle; the request is accepted at the next edge.
    task automatic issue(input bit wr, input logic [7:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rd, input bit expect_ack);
        ram_avalid = 1'b1;
        ram_wr     = wr;
        ram_addr   = a;
        ram_wdata  = d;
        @(posedge clk); #1;
        if (expect_ack) begin
            sb.push_back('{wr, exp_rd, cyc + LATENCY});
            n_issued++;
        end
        ram_avalid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k;
        for (k = 0; k < 60; k++) begin
            if (n_acks >= n_issued && !ram_busy) break;
            @(posedge clk); #1;
        end
        if (k == 60) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s_timeout: got no completion, required ack within 60 cycles", name);
        end
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int e0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack",   32'(ram_ack),  32'd0);
        check("rst_busy",  32'(ram_busy), 32'd0);
        check("rst_rdata", ram_rdata,     32'h0);
`ifdef RAM_STATS_EN
        check("rst_stat_rd", 32'(stat_rd), 32'd0);
        check("rst_stat_wr", 32'(stat_wr), 32'd0);
`endif
        not_reset = 1'b1;
        @(posedge clk); #1;

        // Basic write then read; avalid drops right after acceptance in every issue.
        issue(1'b1, 8'h10, 32'hDEADBEEF, 32'h0, 1'b1);
        check("busy_in_wait", 32'(ram_busy), 32'd1);
        wait_done("wr10");
        issue(1'b0, 8'h10, 32'h0, 32'hDEADBEEF, 1'b1);
        wait_done("rd10");

        // Back-to-back: avalid held through the ack, write then fill of 8'h01.
        ram_avalid = 1'b1; ram_wr = 1'b1; ram_addr = 8'h01; ram_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        e0 = cyc;
        sb.push_back('{1'b1, 32'h0, e0 + LATENCY});
        sb.push_back('{1'b0, 32'hCAFEF00D, e0 + 2 * LATENCY + 2});
        n_issued += 2;
        ram_wr = 1'b0; ram_wdata = 32'h0;
        while (cyc < e0 + LATENCY + 2) begin
            @(posedge clk); #1;
        end
        ram_avalid = 1'b0;
        wait_done("b2b");

        // Inputs wiggle during WAIT; only the accepted values may be used.
        issue(1'b1, 8'h30, 32'h12345678, 32'h0, 1'b1);
        for (int i = 0; i < LATENCY + 1; i++) begin
            ram_addr  = 8'h31 + 8'(i);
            ram_wdata = 32'hFFFF0000 ^ 32'(i);
            ram_wr    = 1'(i);
            @(posedge clk); #1;
        end
        wait_done("wiggle");
        issue(1'b0, 8'h30, 32'h0, 32'h12345678, 1'b1);
        wait_done("rd30");

        // Read after overwrite returns new data; neighbour line untouched; writes leave rdata alone.
        issue(1'b1, 8'h10, 32'h01234567, 32'h0, 1'b1);
        wait_done("wr10b");
        check("rdata_hold_after_wr", ram_rdata, 32'h12345678);
        issue(1'b0, 8'h10, 32'h0, 32'h01234567, 1'b1);
        wait_done("rd10b");
        issue(1'b0, 8'h01, 32'h0, 32'hCAFEF00D, 1'b1);
        wait_done("rd01");

        // Reset mid-WAIT of a write: no ack, write lost, old value kept.
        issue(1'b1, 8'h20, 32'h0, 32'h0, 1'b1);
        wait_done("wr20");
        issue(1'b1, 8'h20, 32'hAAAA5555, 32'h0, 1'b0);
        @(posedge clk); #1;
        not_reset = 1'b0;
        #1;
        check("midrst_busy",  32'(ram_busy), 32'd0);
        check("midrst_ack",   32'(ram_ack),  32'd0);
        check("midrst_rdata", ram_rdata,     32'h0);
        @(posedge clk); #1;
        not_reset = 1'b1;
        repeat (LATENCY + 3) begin
            @(posedge clk); #1;
        end
        issue(1'b0, 8'h20, 32'h0, 32'h0, 1'b1);
        wait_done("rd20");
        issue(1'b0, 8'h10, 32'h0, 32'h01234567, 1'b1);
        wait_done("rd10_after_rst");

`ifdef RAM_STATS_EN
        // Counters saturate at 3 with STAT_W=2.
        not_reset = 1'b0;
        @(posedge clk); #1;
        not_reset = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            issue(1'b0, 8'h10, 32'h0, 32'h01234567, 1'b1);
            wait_done("stat_rd");
            check("stat_rd", 32'(stat_rd), (i > 3) ? 32'd3 : 32'(i));
        end
        check("stat_wr", 32'(stat_wr), 32'd0);
`endif

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
